// File: rtl/l1_ins_miss_handler_pkg.sv
// Shared widths, helpers and FSM encoding for the L1 instruction miss handler.
// Default geometry: 32-bit addresses, 512 x 2-way lines of 16 x 4-byte words.
package l1_ins_miss_handler_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    localparam int ADDRESS_WIDTH_DEF  = 32;
    localparam int MEMORY_DEPTH_DEF   = 512;
    localparam int WORD_SIZE_DEF      = 4;
    localparam int WORD_PER_BLOCK_DEF = 16;
    localparam int BLOCK_WIDTH_DEF    = WORD_SIZE_DEF * WORD_PER_BLOCK_DEF * 8;

    localparam int BYTE_SELECT = clog2(WORD_SIZE_DEF);
    localparam int WORD_SELECT = clog2(WORD_PER_BLOCK_DEF);
    localparam int LINE_SELECT = clog2(MEMORY_DEPTH_DEF);
    localparam int TAG_WIDTH   =
        ADDRESS_WIDTH_DEF - (LINE_SELECT + WORD_SELECT + BYTE_SELECT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND_ADDR,
        S_WAIT_DATA,
        S_WRITE
    } state_t;

endpackage

// File: rtl/l1_ins_miss_handler_if.sv
// L2 refill channel: address request out, line response back.
// master = miss handler side, slave = L2 side.
interface l1_ins_miss_handler_if
    import l1_ins_miss_handler_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
    parameter int BLOCK_WIDTH   = BLOCK_WIDTH_DEF
);
    logic                     ADDRESS_TO_L2_READY_INS;
    logic                     ADDRESS_TO_L2_VALID_INS;
    logic [ADDRESS_WIDTH-3:0] ADDRESS_TO_L2_INS;
    logic                     DATA_FROM_L2_READY_INS;
    logic                     DATA_FROM_L2_VALID_INS;
    logic [BLOCK_WIDTH-1:0]   DATA_FROM_L2_INS;

    modport master (
        input  ADDRESS_TO_L2_READY_INS,
        output ADDRESS_TO_L2_VALID_INS,
        output ADDRESS_TO_L2_INS,
        output DATA_FROM_L2_READY_INS,
        input  DATA_FROM_L2_VALID_INS,
        input  DATA_FROM_L2_INS
    );

    modport slave (
        output ADDRESS_TO_L2_READY_INS,
        input  ADDRESS_TO_L2_VALID_INS,
        input  ADDRESS_TO_L2_INS,
        input  DATA_FROM_L2_READY_INS,
        output DATA_FROM_L2_VALID_INS,
        output DATA_FROM_L2_INS
    );
endinterface

// File: rtl/l1_ins_miss_handler_lru.sv
// One LRU bit per line: 0 means bank 0 is the next victim.
// Async read for the lookup, one sync write port, sync clear.
module lru_bit_array
    import l1_ins_miss_handler_pkg::*;
#(
    parameter int DEPTH = 1 << LINE_SELECT,
    parameter int AW    = clog2(DEPTH)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_data,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic          wr_data
);
    logic [DEPTH-1:0] bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            bits <= '0;
        end else if (we) begin
            bits[wr_addr] <= wr_data;
        end
    end

    assign rd_data = bits[rd_addr];
endmodule

// File: rtl/l1_ins_miss_handler.sv
// Two-way L1 instruction cache miss handler: stalls fetch, requests the
// line from L2, and writes it into the LRU victim bank.
module l1_ins_miss_handler
    import l1_ins_miss_handler_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = TAG_WIDTH + LINE_SELECT + WORD_SELECT + BYTE_SELECT,
    parameter int BLOCK_WIDTH    = BLOCK_WIDTH_DEF,
    parameter int MEMORY_DEPTH   = 1 << LINE_SELECT,
    parameter int WORD_SIZE      = 1 << BYTE_SELECT,
    parameter int WORD_PER_BLOCK = 1 << WORD_SELECT,
    localparam int BYTE_W = clog2(WORD_SIZE),
    localparam int WORD_W = clog2(WORD_PER_BLOCK),
    localparam int LINE_W = clog2(MEMORY_DEPTH),
    localparam int TAG_W  = ADDRESS_WIDTH - (LINE_W + WORD_W + BYTE_W)
)(
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     VALID_IF3,
    input  logic [ADDRESS_WIDTH-1:0] PC_IF3,
    input  logic                     HIT_BANK_0,
    input  logic                     HIT_BANK_1,
    output logic                     STALL_IF,
    l1_ins_miss_handler_if.master    l2,
    output logic                     REFILL_WE_BANK_0,
    output logic                     REFILL_WE_BANK_1,
    output logic [LINE_W-1:0]        REFILL_LINE,
    output logic [TAG_W-1:0]         REFILL_TAG,
    output logic [BLOCK_WIDTH-1:0]   REFILL_DATA,
    output logic [31:0]              MISS_COUNT
);
    localparam int PAD = BYTE_W + WORD_W - 2;

    state_t                   state;
    logic [TAG_W+LINE_W-1:0]  pc_q;
    logic                     victim_q;
    logic                     addr_valid_q;
    logic                     data_ready_q;

    logic                     miss;
    logic                     hit;
    logic [LINE_W-1:0]        pc_line;
    logic                     lru_rd;
    logic                     lru_we;
    logic [LINE_W-1:0]        lru_wa;
    logic                     lru_wd;
    logic                     unused_pc;

    assign pc_line   = PC_IF3[BYTE_W+WORD_W +: LINE_W];
    assign miss      = VALID_IF3 & ~HIT_BANK_0 & ~HIT_BANK_1;
    assign hit       = VALID_IF3 & (HIT_BANK_0 | HIT_BANK_1);
    assign unused_pc = ^PC_IF3[BYTE_W+WORD_W-1:0];

    assign STALL_IF = ~RST & ((state != S_IDLE) | (state == S_IDLE & miss));

    assign l2.ADDRESS_TO_L2_VALID_INS = addr_valid_q;
    assign l2.ADDRESS_TO_L2_INS       = {pc_q, PAD'(0)};
    assign l2.DATA_FROM_L2_READY_INS  = data_ready_q;

    assign REFILL_LINE = pc_q[LINE_W-1:0];
    assign REFILL_TAG  = pc_q[LINE_W +: TAG_W];

    // Hit in bank 0 (including a double hit) makes bank 1 the next victim.
    always_comb begin
        lru_we = 1'b0;
        lru_wa = pc_line;
        lru_wd = HIT_BANK_0;
        if (state == S_WRITE) begin
            lru_we = 1'b1;
            lru_wa = REFILL_LINE;
            lru_wd = ~victim_q;
        end else if (state == S_IDLE && hit) begin
            lru_we = 1'b1;
        end
    end

    lru_bit_array #(
        .DEPTH (MEMORY_DEPTH),
        .AW    (LINE_W)
    ) u_lru (
        .clk     (CLK),
        .rst     (RST),
        .rd_addr (pc_line),
        .rd_data (lru_rd),
        .we      (lru_we),
        .wr_addr (lru_wa),
        .wr_data (lru_wd)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state            <= S_IDLE;
            pc_q             <= '0;
            victim_q         <= 1'b0;
            addr_valid_q     <= 1'b0;
            data_ready_q     <= 1'b0;
            REFILL_WE_BANK_0 <= 1'b0;
            REFILL_WE_BANK_1 <= 1'b0;
            REFILL_DATA      <= '0;
            MISS_COUNT       <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (miss) begin
                        state        <= S_SEND_ADDR;
                        pc_q         <= PC_IF3[ADDRESS_WIDTH-1:BYTE_W+WORD_W];
                        victim_q     <= lru_rd;
                        addr_valid_q <= 1'b1;
                        if (MISS_COUNT != '1) begin
                            MISS_COUNT <= MISS_COUNT + 32'd1;
                        end
                    end
                end
                S_SEND_ADDR: begin
                    if (l2.ADDRESS_TO_L2_READY_INS) begin
                        state        <= S_WAIT_DATA;
                        addr_valid_q <= 1'b0;
                        data_ready_q <= 1'b1;
                    end
                end
                S_WAIT_DATA: begin
                    if (l2.DATA_FROM_L2_VALID_INS) begin
                        state            <= S_WRITE;
                        data_ready_q     <= 1'b0;
                        REFILL_DATA      <= l2.DATA_FROM_L2_INS;
                        REFILL_WE_BANK_0 <= ~victim_q;
                        REFILL_WE_BANK_1 <= victim_q;
                    end
                end
                S_WRITE: begin
                    state            <= S_IDLE;
                    REFILL_WE_BANK_0 <= 1'b0;
                    REFILL_WE_BANK_1 <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
